frv_mem_responder: RTL and testbench

- Responder (memory-side) end of the frv_core imem/dmem req/gnt/recv/ack interface.
- Backs the interface with a word-addressed on-chip RAM with a fixed access latency, bounded outstanding requests, and optional stall injection.
- Used as the instruction or data memory model in simulation benches and as a tightly coupled memory in SoC integrations.

---
 rtl/frv_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_frv_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/frv_mem_responder.sv
// frv_mem_responder: memory-side end of the frv_core req/gnt/recv/ack bus.
// Word-addressed RAM behind a fixed-latency response pipeline and an
// in-order response FIFO. The credit counter limits how many requests can be
// outstanding, so the FIFO can never overflow.
module frv_mem_responder #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata,
  input  logic        stall_in
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] RSP_MAX  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]   mem_q [MEM_DEPTH];
  rsp_t          fifo_q [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] outst_q, outst_d;

  logic          accept;
  logic          pop;
  logic          addr_err;
  logic [AW-1:0] word_idx;
  rsp_t          new_rsp;
  rsp_t          stg_out;
  logic          stg_out_vld;
  rsp_t          head;
  logic          addr_lsb_unused;

  assign addr_lsb_unused = ^mem_addr[1:0];
  assign addr_err = |mem_addr[31:AW+2];
  assign word_idx = mem_addr[AW+1:2];

  assign mem_recv = (cnt_q != '0);
  assign pop      = mem_recv && mem_ack;
  // A pop in the same cycle frees a credit, so a full responder can still
  // grant while the initiator is acknowledging.
  assign mem_gnt  = !g_reset && !stall_in && ((outst_q < RSP_MAX) || pop);
  assign accept   = mem_req && mem_gnt;

  // Response for the request accepted this cycle; the RAM read is taken now
  // so a read right after a write to the same word sees the new data.
  always_comb begin
    new_rsp = '0;
    if (addr_err) begin
      new_rsp.err = 1'b1;
    end else if (!mem_wen) begin
      new_rsp.data = mem_q[word_idx];
    end
  end

  // Byte-strobed RAM write at the accept edge; contents survive reset.
  always_ff @(posedge g_clk) begin
    if (accept && mem_wen && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_strb[i]) mem_q[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign stg_out_vld = accept;
      assign stg_out     = new_rsp;
    end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic [NS-1:0] vld_q, vld_d;
      rsp_t          ent_q [NS];
      rsp_t          ent_d [NS];

      // Advance accepted responses one stage per cycle toward the FIFO.
      always_comb begin
        vld_d[0] = accept;
        ent_d[0] = new_rsp;
        for (int i = 1; i < NS; i++) begin
          vld_d[i] = vld_q[i-1];
          ent_d[i] = ent_q[i-1];
        end
      end

      // Latency pipeline registers, flushed on reset.
      always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
          vld_q <= '0;
          for (int i = 0; i < NS; i++) ent_q[i] <= '0;
        end else begin
          vld_q <= vld_d;
          ent_q <= ent_d;
        end
      end

      assign stg_out_vld = vld_q[NS-1];
      assign stg_out     = ent_q[NS-1];
    end
  endgenerate

  // Next-state for FIFO pointers/occupancy and the credit counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    outst_d  = outst_q;
    if (stg_out_vld) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({stg_out_vld, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({accept, pop})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // FIFO control and credit registers.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
    end
  end

  // FIFO storage; validity is tracked by cnt_q so the data needs no reset.
  always_ff @(posedge g_clk) begin
    if (stg_out_vld) fifo_q[wr_ptr_q] <= stg_out;
  end

  assign head      = fifo_q[rd_ptr_q];
  assign mem_rdata = mem_recv ? head.data : 32'd0;
  assign mem_error = mem_recv && head.err;

  a_recv_has_credit: assert property (@(posedge g_clk) disable iff (g_reset)
    mem_recv |-> (outst_q != '0));
  a_credit_bound: assert property (@(posedge g_clk) disable iff (g_reset)
    outst_q <= RSP_MAX);

endmodule

// File: tb/tb_frv_mem_responder.sv
// Randomised bench for frv_mem_responder against a transaction-level model:
// a word array for memory and a queue of expected responses, each stamped
// with the earliest cycle it may appear.
module tb_frv_mem_responder;

  localparam int M = 1024;
  localparam int L = 2;
  localparam int D = 2;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        mem_req;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;
  logic        stall_in;

  frv_mem_responder #(.MEM_DEPTH(M), .LATENCY(L), .RSP_DEPTH(D)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_recv  (mem_recv),
    .mem_ack   (mem_ack),
    .mem_error (mem_error),
    .mem_rdata (mem_rdata),
    .stall_in  (stall_in)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          rdy;
  } exp_t;

  exp_t        rspq[$];
  logic [31:0] mdl_mem [M];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One bus cycle: drive, compare against the model, then advance the model
  // at the clock edge. Called #1 after a rising edge.
  task automatic step(input logic req, input logic wen, input logic [3:0] strb,
                      input logic [31:0] wdata, input logic [31:0] addr,
                      input logic ack, input logic stall, output logic acc);
    logic        e_recv, e_gnt, e_err;
    logic [31:0] e_data;
    int unsigned idx;
    exp_t        ent;
    mem_req = req; mem_wen = wen; mem_strb = strb; mem_wdata = wdata;
    mem_addr = addr; mem_ack = ack; stall_in = stall;
    #2;
    e_recv = (rspq.size() > 0) && (rspq[0].rdy <= cyc);
    e_err  = e_recv ? rspq[0].err : 1'b0;
    e_data = e_recv ? rspq[0].data : 32'd0;
    e_gnt  = !stall && ((rspq.size() < D) || (e_recv && ack));
    chk("gnt", mem_gnt, e_gnt);
    chk("recv", mem_recv, e_recv);
    chk("error", mem_error, e_err);
    chk("rdata", mem_rdata, e_data);
    acc = req && e_gnt;
    @(posedge g_clk);
    if (e_recv && ack) void'(rspq.pop_front());
    if (acc) begin
      idx = addr[31:2];
      ent.err = 1'b0; ent.data = 32'd0; ent.rdy = cyc + L;
      if (idx >= M) ent.err = 1'b1;
      else if (wen) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) mdl_mem[idx][8*i +: 8] = wdata[8*i +: 8];
      end else ent.data = mdl_mem[idx];
      rspq.push_back(ent);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input logic ack);
    logic a;
    step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, ack, 1'b0, a);
  endtask

  task automatic xfer(input logic wen, input logic [3:0] strb,
                      input logic [31:0] wdata, input logic [31:0] addr);
    logic a;
    a = 1'b0;
    for (int n = 0; n < 50 && !a; n++) step(1'b1, wen, strb, wdata, addr, 1'b1, 1'b0, a);
    if (!a) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && rspq.size() != 0; n++) idle(1'b1);
    if (rspq.size() != 0) chk("drain_timeout", rspq.size(), 0);
  endtask

  task automatic do_reset();
    g_reset = 1'b1; mem_req = 1'b0; mem_ack = 1'b0; stall_in = 1'b0;
    #1;
    chk("rst_recv", mem_recv, 0);
    chk("rst_gnt", mem_gnt, 0);
    chk("rst_error", mem_error, 0);
    chk("rst_rdata", mem_rdata, 0);
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    rspq.delete();
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a;
    int unsigned r, w;
    logic [31:0] addr;

    g_reset = 1'b1; mem_req = 1'b0; mem_wen = 1'b0; mem_strb = 4'h0;
    mem_wdata = 32'd0; mem_addr = 32'd0; mem_ack = 1'b0; stall_in = 1'b0;
    for (int i = 0; i < M; i++) mdl_mem[i] = 32'd0;
    @(posedge g_clk);
    #1;
    do_reset();

    // preload the words used by the rest of the run
    for (int i = 0; i < 16; i++) xfer(1'b1, 4'hF, $urandom, 32'(i * 4));
    xfer(1'b1, 4'hF, $urandom, 32'(1023 * 4));
    xfer(1'b1, 4'hF, 32'hDEADBEEF, 32'h14);
    xfer(1'b1, 4'hF, 32'h11223344, 32'h0C);
    drain();

    // basic read with latency 2
    step(1'b1, 1'b0, 4'h0, 32'd0, 32'h14, 1'b0, 1'b0, a);
    chk("basic_acc", a, 1);
    idle(1'b0);
    #1;
    chk("basic_recv", mem_recv, 1);
    chk("basic_rdata", mem_rdata, 32'hDEADBEEF);
    idle(1'b1);
    idle(1'b0);

    // strobed write then read of the same word next cycle
    step(1'b1, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h0C, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 4'h0, 32'd0, 32'h0C, 1'b0, 1'b0, a);
    #1;
    chk("wr_rsp_rdata", mem_rdata, 32'd0);
    idle(1'b1);
    #1;
    chk("strb_rdata", mem_rdata, 32'h11BB33DD);
    idle(1'b1);
    drain();

    // out of range read and write, then word 0 must be untouched
    step(1'b1, 1'b0, 4'h0, 32'd0, 32'h1000, 1'b0, 1'b0, a);
    idle(1'b0);
    #1;
    chk("oor_rd_err", mem_error, 1);
    idle(1'b1);
    step(1'b1, 1'b1, 4'hF, 32'h5A5A5A5A, 32'h1000, 1'b0, 1'b0, a);
    idle(1'b0);
    #1;
    chk("oor_wr_err", mem_error, 1);
    idle(1'b1);
    xfer(1'b0, 4'h0, 32'd0, 32'h0);
    drain();

    // backpressure: two accepts then no grant until an ack
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, 32'd0, 32'h4, 1'b0, 1'b0, a);
    #1;
    chk("bp_full_gnt", mem_gnt, 0);
    step(1'b1, 1'b0, 4'h0, 32'd0, 32'h8, 1'b1, 1'b0, a);
    chk("bp_ack_acc", a, 1);
    drain();

    // accept and pop together at one outstanding; then stall
    step(1'b1, 1'b0, 4'h0, 32'd0, 32'h10, 1'b0, 1'b0, a);
    idle(1'b0);
    step(1'b1, 1'b0, 4'h0, 32'd0, 32'h18, 1'b1, 1'b0, a);
    chk("sim_acc", a, 1);
    step(1'b1, 1'b0, 4'h0, 32'd0, 32'h18, 1'b1, 1'b1, a);
    drain();

    // reset with a write and a read in flight
    step(1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 32'h1C, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 4'h0, 32'd0, 32'h20, 1'b0, 1'b0, a);
    do_reset();
    for (int i = 0; i < 5; i++) idle(1'b1);
    xfer(1'b0, 4'h0, 32'd0, 32'h1C);
    drain();

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) do_reset();
      r = $urandom_range(16);
      w = (r == 16) ? 1023 : r;
      addr = ($urandom_range(9) == 0) ? ($urandom | 32'h0000_1000) : (32'(w * 4) | 32'($urandom_range(3)));
      step($urandom_range(3) != 0, $urandom_range(2) == 0, 4'($urandom), $urandom, addr,
           $urandom_range(2) != 0, $urandom_range(7) == 0, a);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
